axi_lite_master: RTL and testbench

- AXI4-Lite initiator that drives the slave-side AXI interface of the hashtable wrapper. It is used by the test harness and by on-chip control logic.
- Converts a simple valid/ready command stream (write = insert/delete register access, read = lookup result) into AXI4-Lite AW/W/B or AR/R transactions.
- Returns one response word per command.
- Only one transaction is outstanding at a time; commands complete strictly in order.

---
 rtl/axi_lite_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator. Turns a valid/ready command stream into one AW/W/B
// or AR/R transaction at a time and returns one response word per command.
// Every output comes straight from a flop, so no input reaches an output
// without passing through a register.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // write address channel
  output logic                  AWVALID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [2:0]            AWPROT,
  input  logic                  AWREADY,
  // write data channel
  output logic                  WVALID,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WREADY,
  // write response channel
  input  logic                  BVALID,
  input  logic [1:0]            BRESP,
  output logic                  BREADY,
  // read address channel
  output logic                  ARVALID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [2:0]            ARPROT,
  input  logic                  ARREADY,
  // read data channel
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_reg, state_next;
  logic                  aw_done_reg, aw_done_next;
  logic                  w_done_reg, w_done_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  awvalid_reg, awvalid_next;
  logic                  wvalid_reg, wvalid_next;
  logic                  bready_reg, bready_next;
  logic                  arvalid_reg, arvalid_next;
  logic                  rready_reg, rready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_write_reg, rsp_write_next;
  logic [ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
  logic [ADDR_WIDTH-1:0] araddr_reg, araddr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_WIDTH-1:0] wstrb_reg, wstrb_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]            rsp_resp_reg, rsp_resp_next;

  // Handshakes use the registered VALID/READY this block drives.
  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;
  logic aw_done_now, w_done_now;

  assign cmd_hs      = cmd_valid & cmd_ready_reg;
  assign aw_hs       = awvalid_reg & AWREADY;
  assign w_hs        = wvalid_reg & WREADY;
  assign b_hs        = BVALID & bready_reg;
  assign ar_hs       = arvalid_reg & ARREADY;
  assign r_hs        = RVALID & rready_reg;
  assign rsp_hs      = rsp_valid_reg & rsp_ready;
  // AW and W finish independently; "now" includes a handshake this cycle.
  assign aw_done_now = aw_done_reg | aw_hs;
  assign w_done_now  = w_done_reg | w_hs;

  // State and all output registers; reset abandons any transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      cmd_ready_reg <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      awaddr_reg    <= '0;
      araddr_reg    <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      cmd_ready_reg <= cmd_ready_next;
      awvalid_reg   <= awvalid_next;
      wvalid_reg    <= wvalid_next;
      bready_reg    <= bready_next;
      arvalid_reg   <= arvalid_next;
      rready_reg    <= rready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_write_reg <= rsp_write_next;
      awaddr_reg    <= awaddr_next;
      araddr_reg    <= araddr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // Next-state selection: one transaction in flight, strictly in order.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_hs) state_next = cmd_write ? WR : RD_ADDR;
      WR:      if (aw_done_now && w_done_now) state_next = WR_RESP;
      WR_RESP: if (b_hs) state_next = RSP;
      RD_ADDR: if (ar_hs) state_next = RD_DATA;
      RD_DATA: if (r_hs) state_next = RSP;
      RSP:     if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    // cmd_ready is high in exactly the cycles spent in IDLE after reset.
    cmd_ready_next = (state_next == IDLE);
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    awvalid_next   = awvalid_reg;
    wvalid_next    = wvalid_reg;
    bready_next    = bready_reg;
    arvalid_next   = arvalid_reg;
    rready_next    = rready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_write_next = rsp_write_reg;
    awaddr_next    = awaddr_reg;
    araddr_next    = araddr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_write) begin
            awaddr_next  = cmd_addr;
            wdata_next   = cmd_wdata;
            wstrb_next   = cmd_wstrb;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
          end else begin
            araddr_next  = cmd_addr;
            arvalid_next = 1'b1;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_next = 1'b0;
        if (w_hs) wvalid_next = 1'b0;
        aw_done_next = aw_done_now;
        w_done_next  = w_done_now;
        // B is only accepted once both address and data are through.
        if (aw_done_now && w_done_now) bready_next = 1'b1;
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_next    = 1'b0;
          rsp_resp_next  = BRESP;
          rsp_write_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_valid_next = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_next    = 1'b0;
          rsp_rdata_next = RDATA;
          rsp_resp_next  = RRESP;
          rsp_write_next = 1'b0;
          rsp_valid_next = 1'b1;
        end
      end
      RSP: begin
        if (rsp_hs) rsp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign AWVALID   = awvalid_reg;
  assign AWADDR    = awaddr_reg;
  assign AWPROT    = 3'b000;
  assign WVALID    = wvalid_reg;
  assign WDATA     = wdata_reg;
  assign WSTRB     = wstrb_reg;
  assign BREADY    = bready_reg;
  assign ARVALID   = arvalid_reg;
  assign ARADDR    = araddr_reg;
  assign ARPROT    = 3'b000;
  assign RREADY    = rready_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-configurable AXI-Lite slave, a
// transaction-level model of what each command must produce, and directed
// tests with hand-computed latencies and response values.
module tb_axi_lite_master;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave configuration, set by the test sequence before each command
  int          cfg_aw_delay, cfg_w_delay, cfg_ar_delay, cfg_b_delay, cfg_r_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  // model / slave state, owned by the slave-monitor process
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          aw_got, w_got, ar_got, busy, rsp_due;
  logic        cur_write;
  logic [3:0]  cur_addr, cur_wstrb;
  logic [31:0] cur_wdata;
  logic        exp_write;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;
  int          n_aw, n_w, n_ar, n_rsp;
  int          acc_cyc, aw_cyc, w_cyc, ar_cyc, b_cyc, r_cyc, bready_cyc, rspv_cyc, rsp_hs_cyc;
  logic [3:0]  cap_awaddr;
  logic [31:0] cap_wdata;
  logic        last_write;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave + model. At each falling edge: drive the slave inputs for the
  // coming rising edge, compare DUT outputs with the model, then book the
  // handshakes that the coming rising edge will complete.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
      BRESP = 2'b01; RRESP = 2'b01; RDATA = 32'hBAD0BAD0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0; busy = 0; rsp_due = 0;
      n_aw = 0; n_w = 0; n_ar = 0;
    end else begin
      AWREADY = AWVALID && (aw_cnt >= cfg_aw_delay);
      if (AWVALID && !AWREADY) aw_cnt++;
      WREADY = WVALID && (w_cnt >= cfg_w_delay);
      if (WVALID && !WREADY) w_cnt++;
      ARREADY = ARVALID && (ar_cnt >= cfg_ar_delay);
      if (ARVALID && !ARREADY) ar_cnt++;
      if (aw_got && w_got && b_cnt < cfg_b_delay) b_cnt++;
      BVALID = aw_got && w_got && (b_cnt >= cfg_b_delay);
      BRESP  = BVALID ? cfg_bresp : 2'b01;
      if (ar_got && r_cnt < cfg_r_delay) r_cnt++;
      RVALID = ar_got && (r_cnt >= cfg_r_delay);
      RRESP  = RVALID ? cfg_rresp : 2'b01;
      RDATA  = RVALID ? cfg_rdata : 32'hBAD0BAD0;

      // per-cycle comparisons against the model
      chk("prot", {AWPROT, ARPROT}, 6'd0);
      chk("rsp_valid", rsp_valid, rsp_due);
      if (cmd_ready) chk("cmd_ready_while_busy", busy, 1'b0);
      if (AWVALID) begin
        chk("awvalid_for_write", busy && cur_write, 1'b1);
        chk("awaddr", AWADDR, cur_addr);
      end
      if (WVALID) begin
        chk("wvalid_for_write", busy && cur_write, 1'b1);
        chk("wdata", {WSTRB, WDATA}, {cur_wstrb, cur_wdata});
      end
      if (ARVALID) begin
        chk("arvalid_for_read", busy && !cur_write, 1'b1);
        chk("araddr", ARADDR, cur_addr);
      end
      if (BREADY) chk("bready_after_aw_w", (n_aw == 1) && (n_w == 1), 1'b1);
      if (RREADY) chk("rready_after_ar", n_ar == 1, 1'b1);
      if (rsp_valid) chk("rsp_fields", {rsp_write, rsp_rdata, rsp_resp},
                         {exp_write, exp_rdata, exp_resp});

      // handshakes completing at the coming rising edge
      if (BREADY && bready_cyc < 0) bready_cyc = cyc;
      if (rsp_valid && rspv_cyc < 0) rspv_cyc = cyc;
      if (cmd_valid && cmd_ready) begin
        busy = 1; cur_write = cmd_write; cur_addr = cmd_addr;
        cur_wdata = cmd_wdata; cur_wstrb = cmd_wstrb;
        exp_write = cmd_write;
        exp_rdata = cmd_write ? 32'h0 : cfg_rdata;
        exp_resp  = cmd_write ? cfg_bresp : cfg_rresp;
        n_aw = 0; n_w = 0; n_ar = 0;
        acc_cyc = cyc; bready_cyc = -1; rspv_cyc = -1;
      end
      if (AWVALID && AWREADY) begin
        n_aw++; aw_cyc = cyc; aw_got = 1; aw_cnt = 0; cap_awaddr = AWADDR;
      end
      if (WVALID && WREADY) begin
        n_w++; w_cyc = cyc; w_got = 1; w_cnt = 0; cap_wdata = WDATA;
      end
      if (ARVALID && ARREADY) begin
        n_ar++; ar_cyc = cyc; ar_got = 1; ar_cnt = 0;
      end
      if (BVALID && BREADY) begin
        chk("one_aw_one_w", (n_aw == 1) && (n_w == 1), 1'b1);
        rsp_due = 1; b_cyc = cyc; aw_got = 0; w_got = 0; b_cnt = 0;
      end
      if (RVALID && RREADY) begin
        chk("one_ar", n_ar == 1, 1'b1);
        rsp_due = 1; r_cyc = cyc; ar_got = 0; r_cnt = 0;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_due = 0; busy = 0; rsp_hs_cyc = cyc; n_rsp++;
        last_write = rsp_write; last_rdata = rsp_rdata; last_resp = rsp_resp;
      end
    end
  end

  task automatic set_slave(input int awd, input int wd, input int ard, input int bd, input int rd,
                           input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rdat);
    cfg_aw_delay = awd; cfg_w_delay = wd; cfg_ar_delay = ard;
    cfg_b_delay = bd; cfg_r_delay = rd;
    cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rdat;
  endtask

  task automatic put_cmd(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    cmd_valid = 0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0; cmd_addr = 4'h0;
  endtask

  task automatic wait_rsp(input int target);
    bit ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge clk); #2;
      if (n_rsp >= target) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: responses=%0d required %0d", n_rsp, target);
    end
    $display("txn %0d: write=%0b rdata=%h resp=%0d", n_rsp, last_write, last_rdata, last_resp);
  endtask

  task automatic do_txn(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int target;
    target = n_rsp + 1;
    put_cmd(w, a, d, s);
    wait_accept();
    wait_rsp(target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, seen;
    bit ok;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 1; n_rsp = 0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    #1 reset = 0;
    #2;
    chk("reset_valids", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 7'd0);
    chk("reset_addr_data", {AWADDR, ARADDR, WDATA, WSTRB}, 44'd0);
    chk("reset_rsp", {rsp_write, rsp_rdata, rsp_resp}, 35'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1;

    // minimum-latency write
    do_txn(1'b1, 4'h2, 32'hDEADBEEF, 4'hF);
    chk("t1_aw_lat", aw_cyc - acc_cyc, 1);
    chk("t1_w_lat", w_cyc - acc_cyc, 1);
    chk("t1_b_lat", b_cyc - acc_cyc, 2);
    chk("t1_rsp_lat", rspv_cyc - acc_cyc, 3);
    chk("t1_awaddr", cap_awaddr, 4'h2);
    chk("t1_wdata", cap_wdata, 32'hDEADBEEF);
    chk("t1_rsp", {last_write, last_rdata, last_resp}, {1'b1, 32'h0, 2'b00});

    // read with ARREADY held off three cycles
    set_slave(0, 0, 3, 0, 0, 2'b00, 2'b00, 32'h12345678);
    do_txn(1'b0, 4'h3, 32'h0, 4'h0);
    chk("t2_ar_lat", ar_cyc - acc_cyc, 4);
    chk("t2_rsp_lat", rspv_cyc - acc_cyc, 6);
    chk("t2_rsp", {last_write, last_rdata, last_resp}, {1'b0, 32'h12345678, 2'b00});

    // AW/W ordering: W late, AW late, both together
    set_slave(0, 4, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1'b1, 4'h4, 32'h11112222, 4'h3);
    chk("t3a_bready_lat", bready_cyc - acc_cyc, 6);
    chk("t3a_counts", {n_aw[7:0], n_w[7:0]}, 16'h0101);
    set_slave(4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1'b1, 4'h5, 32'h33334444, 4'hC);
    chk("t3b_bready_lat", bready_cyc - acc_cyc, 6);
    chk("t3b_counts", {n_aw[7:0], n_w[7:0]}, 16'h0101);
    set_slave(2, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    do_txn(1'b1, 4'h6, 32'h55556666, 4'h1);
    chk("t3c_bready_lat", bready_cyc - acc_cyc, 4);
    chk("t3c_counts", {n_aw[7:0], n_w[7:0]}, 16'h0101);

    // error responses pass through in order
    set_slave(0, 0, 0, 0, 2, 2'b00, 2'b10, 32'h0BADF00D);
    do_txn(1'b0, 4'h7, 32'h0, 4'h0);
    chk("t4_slverr", {last_write, last_resp}, {1'b0, 2'b10});
    set_slave(0, 0, 0, 2, 0, 2'b11, 2'b00, 32'h0);
    do_txn(1'b1, 4'h8, 32'h77778888, 4'hF);
    chk("t4_decerr", {last_write, last_resp}, {1'b1, 2'b11});

    // response back-pressure with the next command already waiting
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h5A5A0001);
    rsp_ready = 0;
    target = n_rsp + 1;
    put_cmd(1'b1, 4'h5, 32'hA5A5A5A5, 4'hF);
    wait_accept();
    put_cmd(1'b0, 4'h6, 32'h0, 4'h0);
    ok = 0; seen = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; seen = cyc; end
    end
    chk("t5_rsp_seen", ok, 1'b1);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1;
    wait_accept();
    chk("t5_held_cycles", rsp_hs_cyc - seen, 5);
    chk("t5_accept_after_hs", acc_cyc - rsp_hs_cyc, 1);
    chk("t5_first_rsp", {last_write, last_rdata, last_resp}, {1'b1, 32'h0, 2'b00});
    wait_rsp(target + 1);
    chk("t5_second_rsp", {last_write, last_rdata}, {1'b0, 32'h5A5A0001});

    // reset in the middle of a write: W done, AW still pending
    set_slave(10, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    put_cmd(1'b1, 4'hA, 32'h99990000, 4'hF);
    wait_accept();
    @(posedge clk); #3;
    chk("t6_pre_aw_w", {AWVALID, WVALID}, 2'b10);
    reset = 0;
    #1;
    chk("t6_async_clear", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 7'd0);
    chk("t6_async_addr", {AWADDR, WDATA, WSTRB}, 40'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    $display("txn reset: write abandoned");
    @(negedge clk);
    chk("t6_no_residual", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 6'd0);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFEF00D);
    do_txn(1'b0, 4'h9, 32'h0, 4'h0);
    chk("t6_fresh_read", {last_write, last_rdata, last_resp}, {1'b0, 32'hCAFEF00D, 2'b00});
    chk("t6_fresh_lat", rspv_cyc - acc_cyc, 3);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
